// File: rtl/snake_track_if.sv
// snake_track_if: controller/renderer bundle for the snake body store.
// master = game controller + renderer side, slave = snake_track.
interface snake_track_if #(
  parameter int H       = 32,
  parameter int V       = 32,
  parameter int MAX_LEN = 64
);
  localparam int XB = $clog2(H);
  localparam int YB = $clog2(V);
  localparam int IB = $clog2(MAX_LEN);
  localparam int LB = $clog2(MAX_LEN + 1);

  logic          step;
  logic [1:0]    dir;
  logic          grow;
  logic          busy;
  logic          done;
  logic [XB-1:0] head_x;
  logic [YB-1:0] head_y;
  logic [LB-1:0] length;
  logic          self_col;
  logic          wall_col;
  logic          dead;
  logic [IB-1:0] rd_idx;
  logic [XB-1:0] rd_x;
  logic [YB-1:0] rd_y;
  logic          rd_valid;

  modport master (
    output step, dir, grow, rd_idx,
    input  busy, done, head_x, head_y, length,
    input  self_col, wall_col, dead,
    input  rd_x, rd_y, rd_valid
  );

  modport slave (
    input  step, dir, grow, rd_idx,
    output busy, done, head_x, head_y, length,
    output self_col, wall_col, dead,
    output rd_x, rd_y, rd_valid
  );
endinterface

// File: rtl/snake_track.sv
// snake_track: circular-buffer snake body with a move engine.
// A move rotates head_ptr back one slot and writes the new head.
module snake_track #(
  parameter int H        = 32,
  parameter int V        = 32,
  parameter int MAX_LEN  = 64,
  parameter int INIT_LEN = 3,
  parameter int WRAP     = 1
) (
  input logic          clk,
  input logic          reset,
  snake_track_if.slave bus
);
  localparam int XB = $clog2(H);
  localparam int YB = $clog2(V);
  localparam int IB = $clog2(MAX_LEN);
  localparam int LB = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {IDLE, CALC, SCAN, COMMIT} state_t;

  state_t        state;
  logic [XB-1:0] bx [MAX_LEN];
  logic [YB-1:0] by [MAX_LEN];
  logic [IB-1:0] hp;
  logic [LB-1:0] len;
  logic [LB-1:0] kmax;
  logic [LB-1:0] k;
  logic [1:0]    heading;
  logic [1:0]    mv_dir;
  logic          gpend;
  logic          mv_grow;
  logic          hit;
  logic          scol;
  logic          wcol;
  logic          busy;
  logic          done;
  logic [XB-1:0] hx;
  logic [YB-1:0] hy;
  logic [XB-1:0] rx;
  logic [YB-1:0] ry;
  logic          rv;

  logic [XB-1:0] nx;
  logic [YB-1:0] ny;
  logic          at_edge;
  logic          match;
  logic          commit_wr;
  logic [IB-1:0] nhp;
  logic [LB-1:0] nlen;
  logic          dead;

  // Array slot of segment i; MAX_LEN need not be a power of two.
  function automatic logic [IB-1:0] slot(
    input logic [IB-1:0] p,
    input logic [IB-1:0] i
  );
    int s;
    s = int'(p) + int'(i);
    if (s >= MAX_LEN) s = s - MAX_LEN;
    if (s >= MAX_LEN) s = s - MAX_LEN;
    return IB'(s);
  endfunction

  assign dead = scol | wcol;

  always_comb begin
    nx      = hx;
    ny      = hy;
    at_edge = 1'b0;
    case (mv_dir)
      2'd0: begin
        if (hx == XB'(H - 1)) begin
          nx      = '0;
          at_edge = 1'b1;
        end else nx = hx + 1'b1;
      end
      2'd1: begin
        if (hy == YB'(V - 1)) begin
          ny      = '0;
          at_edge = 1'b1;
        end else ny = hy + 1'b1;
      end
      2'd2: begin
        if (hx == '0) begin
          nx      = XB'(H - 1);
          at_edge = 1'b1;
        end else nx = hx - 1'b1;
      end
      default: begin
        if (hy == '0) begin
          ny      = YB'(V - 1);
          at_edge = 1'b1;
        end else ny = hy - 1'b1;
      end
    endcase
  end

  always_comb begin
    match = (bx[slot(hp, IB'(k))] == nx) &&
            (by[slot(hp, IB'(k))] == ny);
    commit_wr = (state == COMMIT) && !hit;
    nhp = hp;
    if (commit_wr)
      nhp = (hp == '0) ? IB'(MAX_LEN - 1) : hp - 1'b1;
    nlen = len;
    if (state == COMMIT && mv_grow && len != LB'(MAX_LEN))
      nlen = len + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      hp      <= '0;
      len     <= LB'(INIT_LEN);
      kmax    <= '0;
      k       <= '0;
      heading <= 2'd0;
      mv_dir  <= 2'd0;
      gpend   <= 1'b0;
      mv_grow <= 1'b0;
      hit     <= 1'b0;
      scol    <= 1'b0;
      wcol    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hx      <= XB'(H / 2);
      hy      <= YB'(V / 2);
      rx      <= '0;
      ry      <= '0;
      rv      <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
        bx[i] <= (i < INIT_LEN) ? XB'(H / 2 - i) : '0;
        by[i] <= (i < INIT_LEN) ? YB'(V / 2) : '0;
      end
    end else begin
      done <= 1'b0;
      if (bus.grow) gpend <= 1'b1;
      unique case (state)
        IDLE: begin
          if (bus.step && !dead) begin
            mv_dir <= (bus.dir == (heading ^ 2'd2)) ?
                      heading : bus.dir;
            busy   <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          if (WRAP == 0 && at_edge) begin
            wcol  <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            // A grow seen here belongs to this move.
            mv_grow <= gpend | bus.grow;
            kmax    <= (gpend | bus.grow) ? len : len - 1'b1;
            gpend   <= 1'b0;
            k       <= '0;
            hit     <= 1'b0;
            state   <= SCAN;
          end
        end
        SCAN: begin
          if (match) hit <= 1'b1;
          k <= k + 1'b1;
          if (k == kmax - 1'b1) state <= COMMIT;
        end
        COMMIT: begin
          if (hit) scol <= 1'b1;
          else begin
            bx[nhp] <= nx;
            by[nhp] <= ny;
            hx      <= nx;
            hy      <= ny;
            heading <= mv_dir;
          end
          hp    <= nhp;
          len   <= nlen;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
      // Read port sees the state that this edge commits.
      rv <= LB'(bus.rd_idx) < nlen;
      if (commit_wr && bus.rd_idx == '0) begin
        rx <= nx;
        ry <= ny;
      end else begin
        rx <= bx[slot(nhp, bus.rd_idx)];
        ry <= by[slot(nhp, bus.rd_idx)];
      end
    end
  end

  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.head_x   = hx;
  assign bus.head_y   = hy;
  assign bus.length   = len;
  assign bus.self_col = scol;
  assign bus.wall_col = wcol;
  assign bus.dead     = dead;
  assign bus.rd_x     = rx;
  assign bus.rd_y     = ry;
  assign bus.rd_valid = rv;
endmodule

// File: doc/snake_track.md
# snake_track

Circular-buffer body store and move engine for the snake game, replacing the shift-the-whole-memory approach with a head pointer so a move costs one write plus a collision scan. It holds up to MAX_LEN segments on an H×V grid, and supports both wrap-around and wall modes. It ignores direction reversal, grows on request, and flags sticky self/wall collisions. It sits between the game controller, which issues `step`/`grow`, and the renderer, which reads segments by index.

## Interface
- H, 32, grid width in cells (any value ≥ 4; xBits = clog2(H))
- V, 32, grid height in cells (any value ≥ 4; yBits = clog2(V))
- MAX_LEN, 64, segment capacity (≥ INIT_LEN; iBits = clog2(MAX_LEN), lBits = clog2(MAX_LEN+1))
- INIT_LEN, 3, length after reset (2..MAX_LEN, < H/2)
- WRAP, 1, 1 = edges wrap modulo H/V; 0 = edges are walls
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- step  in  1  request one move; sampled only when busy=0 and dead=0
- dir  in  2  requested heading, sampled with step: 0 right (x+1), 1 up (y+1), 2 left (x-1), 3 down (y-1)
- grow  in  1  pulse; sets grow_pending (any cycle)
- busy  out  1  move in progress
- done  out  1  one-cycle pulse at end of every accepted move
- head_x / head_y  out  xBits / yBits  current head cell
- length  out  lBits  current segment count
- self_col  out  1  sticky, set when head would enter the body
- wall_col  out  1  sticky, set when head would leave grid (WRAP=0 only)
- dead  out  1  self_col | wall_col
- rd_idx  in  iBits  segment index, 0 = head
- rd_x / rd_y  out  xBits / yBits  segment rd_idx, registered (1-cycle latency)
- rd_valid  out  1  registered (rd_idx < length)

## Operation
- Storage: MAX_LEN-entry register array {x,y}, head_ptr (iBits). Segment i is at array[(head_ptr + i) mod MAX_LEN].
- Reset: head_ptr=0; entry i = (H/2 − i, V/2) for i < INIT_LEN; length=INIT_LEN; heading=right; grow_pending, self_col, wall_col, busy, done=0; rd_x/rd_y/rd_valid=0.
- FSM states: IDLE, CALC, SCAN, COMMIT.
- IDLE → CALC on step & ~dead. Latch dir. If dir is opposite to the current heading, keep the current heading.
- CALC: compute new head from the latched heading.
  - WRAP=1: x=H−1 moving right → 0; x=0 moving left → H−1; same on y with V. Use explicit compares, not power-of-two truncation.
  - WRAP=0: if the same edge cases occur, set wall_col, pulse done, go to IDLE. No state change otherwise.
  - Else compute K = grow_pending ? length : length−1 (the tail vacates unless growing), clear scan index, go to SCAN.
- SCAN: compare the new head with segment k, one per cycle, k = 0..K−1. Set internal hit on a match. The scan always runs all K cycles (no early exit).
- COMMIT:
  - If hit: set self_col; no write.
  - Else: head_ptr ← head_ptr − 1 mod MAX_LEN; write new head at the new head_ptr; heading ← latched heading.
  - If grow_pending: length ← min(length+1, MAX_LEN) and clear grow_pending, even when capped.
  - Then pulse done, go to IDLE.
- grow asserted in the same cycle as the CALC of a move counts toward that move. grow arriving during SCAN/COMMIT applies to the next move.
- dead blocks further steps until reset. Reset in any state aborts immediately to reset values.
- Read port: rd_x/rd_y/rd_valid show the committed state as of the previous clock edge. During COMMIT the reads show the old body; from the cycle after, they show the new body.

## Timing
- step sampled at edge t (IDLE): busy=1 from t+1; CALC occupies cycle t+1.
- Successful or self-hit move: SCAN occupies t+2..t+1+K; COMMIT at t+2+K; done=1, busy=0, head_x/head_y/length/self_col updated in cycle t+3+K.
- Wall hit: done=1, wall_col=1, busy=0 in cycle t+2.
- step while busy or dead: ignored, no queuing.
- Back-to-back: step may be asserted in the done cycle and is accepted.

## Test plan
- Reset with defaults → head (16,16), segments 1,2 at (15,16),(14,16), length=3, busy=0, all flags 0.
- step dir=1 (up) → done exactly 5 cycles after the step edge (K=2). Head (16,17); rd_idx=1 gives (16,16); rd_idx=2 gives (15,16); rd_idx=3 gives rd_valid=0.
- grow pulse then step dir=0 → length=4, latency 6 cycles (K=3), old tail still readable at idx 3. At MAX_LEN, a further grow+step keeps length=MAX_LEN.
- Heading right, step dir=2 (reverse) → moves right anyway, no collision.
- WRAP=1, head at x=31 moving right → head_x=0. WRAP=0, same case → wall_col=1 two cycles after step, head unchanged; later steps ignored until reset.
- With length 5, issue the step sequence up, left, down → self_col=1 at done, head unchanged. Then reset mid-SCAN of a fresh move → busy=0 next cycle and reset state restored.
